// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// The divider is only built when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_div.sv
// Restoring-divide step core on unsigned magnitudes.
// One quotient bit per cycle while step is high; load seeds the registers.
module mdu_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] dsor;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub;
  logic            fits;

  // The partial remainder stays below the divisor, so the XLEN-bit
  // difference is exact whenever the shifted value fits.
  always_comb begin
    shifted = {remainder, quotient[XLEN-1]};
    fits    = shifted >= {1'b0, dsor};
    sub     = shifted[XLEN-1:0] - dsor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dsor      <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dsor      <= divisor;
    end else if (step) begin
      remainder <= fits ? sub : shifted[XLEN-1:0];
      quotient  <= {quotient[XLEN-2:0], fits};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: fixed 33-cycle latency per op.
// Define MDU_DIV_EN to build the divider; otherwise divide ops flag illegal.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  state_t            state, state_next;
  logic              load, step;
  logic [4:0]        cnt, rd_q;
  logic [2:0]        op;
  logic              neg_res, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b, mcand, addend, fin_result;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN:0]     sum;

  always_comb begin
    a_neg = a[XLEN-1] && !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU});
    b_neg = b[XLEN-1] && (funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        load = 1'b1;
`ifdef MDU_DIV_EN
        state_next = RUN;
`else
        state_next = funct3[2] ? FIN : RUN;
`endif
      end
      RUN: begin
        step = 1'b1;
        if (cnt == 5'd31) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    addend = prod[0] ? mcand : '0;
    sum    = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, addend};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      rd_q    <= '0;
      neg_res <= 1'b0;
      mcand   <= '0;
      prod    <= '0;
      cnt     <= '0;
    end else if (load) begin
      op      <= funct3;
      rd_q    <= rd_in;
      neg_res <= a_neg ^ b_neg;
      mcand   <= mag_a;
      prod    <= {{XLEN{1'b0}}, mag_b};
      cnt     <= '0;
    end else if (step) begin
      prod <= {sum, prod[XLEN-1:1]};
      cnt  <= cnt + 5'd1;
    end
  end

`ifdef MDU_DIV_EN
  logic            neg_rem, b_zero;
  logic [XLEN-1:0] quo, rem, q_s, r_s;

  mdu_div #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quo),
    .remainder(rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
    end else if (load) begin
      neg_rem <= a_neg;
      b_zero  <= (b == '0);
    end
  end

  assign illegal = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= (state == FIN) && op[2];
  end
`endif

  // Divide-by-zero quotient is forced; the remainder's dividend sign
  // already reproduces a unchanged, and overflow falls out naturally.
  always_comb begin
    prod_s     = neg_res ? -prod : prod;
    fin_result = (op == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    q_s = b_zero ? DIV_BY_ZERO_Q : (neg_res ? -quo : quo);
    r_s = neg_rem ? -rem : rem;
    if (op[2]) fin_result = op[1] ? r_s : q_s;
`else
    if (op[2]) fin_result = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      if (load) busy <= 1'b1;
      if (state == FIN) begin
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= fin_result;
        rd_out <= rd_q;
      end
    end
  end

endmodule
